regfile_sb: RTL
===============

# regfile_sb

Parametrised integer register file with two write ports, per-byte write enables, read-after-write bypass and a pending-writeback scoreboard. It sits in the decode/writeback stage of the core. Port A carries single-cycle ALU results; port B carries long-latency load writebacks. The scoreboard tracks destination registers that have an outstanding load, so decode can stall on them.

## Interface
- XLEN, 32: register width in bits; must be a multiple of 8.
- NREGS, 32: number of registers; must be a power of 2, at least 2.
- AW, $clog2(NREGS): register address width (derived, not overridden).
- BYPASS, 1: 1 enables same-cycle write-to-read forwarding; 0 returns stored contents only.
- ZERO_REG, 1: 1 hardwires register 0 to zero.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- rs1_addr, rs2_addr  in  AW  read addresses.
- rs1_data, rs2_data  out  XLEN  read data (combinational).
- rs1_busy, rs2_busy  out  1  the addressed register has a pending writeback (combinational).
- wa_en  in  1  port A write strobe.
- wa_addr  in  AW  port A destination.
- wa_be  in  XLEN/8  port A byte enables; bit i covers data bits [8i+7:8i].
- wa_data  in  XLEN  port A data.
- wb_en  in  1  port B (load writeback) strobe; full-word write that also clears busy.
- wb_addr  in  AW  port B destination.
- wb_data  in  XLEN  port B data.
- iss_en  in  1  issue of a long-latency op; sets busy on iss_rd.
- iss_rd  in  AW  destination of the issued op.
- busy_cnt  out  AW+1  number of busy registers (registered).
- sb_err  out  1  sticky scoreboard protocol error (registered).

## Operation
- Storage: NREGS x XLEN flops. Asynchronous reset clears every register, every busy bit, busy_cnt and sb_err to 0, immediately and regardless of clk.
- Port A write at a posedge, when wa_en=1: for each set bit of wa_be, that byte of reg[wa_addr] takes the matching wa_data byte. Unselected bytes hold their value. wa_be=0 writes nothing.
- Port B write at a posedge, when wb_en=1: reg[wb_addr] <= wb_data, full word.
- Both ports to the same address in one cycle: port A bytes win where wa_be=1; port B supplies the remaining bytes. sb_err is not set by this.
- ZERO_REG=1: register 0 always reads 0 and rs*_busy for it is 0. Writes to it, issues to it and writebacks to it are ignored, including for scoreboard and sb_err purposes.
- Read when BYPASS=1: the result starts from the stored word. If wb_en targets the read address, port B data is merged in. If wa_en targets it, port A's enabled bytes are then merged over that. The result equals the post-edge register value.
- Read when BYPASS=0: returns the stored word only.
- rsN_busy is busy[rsN_addr]. When BYPASS=1 it is forced to 0 if wb_en=1 and wb_addr=rsN_addr in the same cycle.
- Scoreboard update at each posedge:
  - wb_en clears busy[wb_addr].
  - iss_en sets busy[iss_rd].
  - Same address in both: set wins, so the register stays busy.
- sb_err is set (sticky until reset) when either:
  - iss_en targets an already-busy register, unless wb_en clears that register in the same cycle; or
  - wb_en targets a non-busy register.
- busy_cnt equals the popcount of the busy vector after each edge. It is maintained incrementally by +1, -1 or 0 and never wraps; the maximum is NREGS-1 when ZERO_REG=1, otherwise NREGS.

## Timing
- Read latency is 0 cycles (combinational from address and state). Write latency is 1 edge.
- The read paths have no dependence on iss_en or iss_rd within a cycle.
- busy bits, busy_cnt and sb_err reflect events from the previous edge. An issue at edge N makes rsN_busy=1 and increments busy_cnt from N onward.
- Reset asserted mid-operation discards any write presented in that cycle. The first write to take effect is at the first posedge after rst_n rises.
- No handshakes: every strobe is accepted in the cycle it is high. Stall policy belongs to decode.

## Test plan
- Reset, then read all addresses: every rs*_data=0, rs*_busy=0, busy_cnt=0, sb_err=0.
- wa_en, addr 5, wa_be=4'b0101, data 0xAABBCCDD over stored 0x11223344: after the edge reg5=0x11BB33DD. In the same cycle with BYPASS=1, rs1_addr=5 reads 0x11BB33DD; with BYPASS=0 it reads 0x11223344.
- Same cycle: wa_en addr 7 be=4'b0011 data 0x0000BEEF, wb_en addr 7 data 0xCAFE0000 -> reg7=0xCAFEBEEF, sb_err stays 0.
- iss_en rd=9 -> rs2_busy(9)=1, busy_cnt=1. Later wb_en addr 9 data 0x12345678 -> rs2_busy(9)=0 and rs2_data=0x12345678 in that cycle; busy_cnt=0 after the edge.
- Same cycle: iss_en rd=3 and wb_en addr 3 with reg3 busy -> stays busy, busy_cnt unchanged, sb_err=0. Then wb_en addr 4 while reg4 is not busy -> sb_err=1, and it remains 1 until rst_n is asserted.
- ZERO_REG=1: wa_en addr 0 data 0xFFFFFFFF be=all and iss_en rd=0 -> rs1_data(0)=0, rs1_busy=0, busy_cnt=0. Assert rst_n low mid-cycle during a write to reg 6 -> reg6=0 immediately and the write is lost.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb -- integer register file for the decode/writeback stage.
//
// Two write ports: port A carries single-cycle ALU results with per-byte
// enables; port B carries full-word load writebacks. A pending-writeback
// scoreboard marks destinations of issued long-latency ops busy until their
// writeback arrives, so decode can stall on them.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   rs1_addr/rs2_addr      read addresses
//   rs1_data/rs2_data      combinational read data (optionally bypassed)
//   rs1_busy/rs2_busy      addressed register has a pending writeback
//   wa_en/wa_addr/wa_be/wa_data   port A byte-enabled write
//   wb_en/wb_addr/wb_data         port B full-word writeback, clears busy
//   iss_en/iss_rd          long-latency issue, sets busy on iss_rd
//   busy_cnt               registered popcount of the busy vector
//   sb_err                 registered sticky scoreboard protocol error
//
// Interface protocol: there is no valid/ready handshake. Every strobe
// (wa_en, wb_en, iss_en) is consumed at the posedge where it is high; any
// back-pressure is decode's job, driven from rs*_busy.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     rs1_addr,
    input  logic [AW-1:0]     rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              wa_en,
    input  logic [AW-1:0]     wa_addr,
    input  logic [XLEN/8-1:0] wa_be,
    input  logic [XLEN-1:0]   wa_data,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_rd,
    output logic [AW:0]       busy_cnt,
    output logic              sb_err
);

    localparam int NB = XLEN / 8;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             err_q;
    logic             err_d;

    // Scoreboard events after removing anything aimed at a hardwired
    // register 0; those must not touch busy, busy_cnt or sb_err.
    logic wb_act;
    logic iss_act;
    logic cnt_inc;
    logic cnt_dec;

    assign wb_act  = wb_en  && !((ZERO_REG != 0) && (wb_addr == '0));
    assign iss_act = iss_en && !((ZERO_REG != 0) && (iss_rd  == '0));

    // Next register contents: port B full word first, then port A's enabled
    // bytes on top, so on an address collision A wins byte-wise.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
            if (wb_en && (wb_addr == AW'(r))) begin
                regs_d[r] = wb_data;
            end
            if (wa_en && (wa_addr == AW'(r))) begin
                for (int b = 0; b < NB; b++) begin
                    if (wa_be[b]) begin
                        regs_d[r][8*b +: 8] = wa_data[8*b +: 8];
                    end
                end
            end
            if ((ZERO_REG != 0) && (r == 0)) begin
                regs_d[r] = '0;
            end
        end
    end

    // With bypass the read returns the post-edge value, which is exactly
    // regs_d; the issue port never feeds this path.
    assign rs1_data = (BYPASS != 0) ? regs_d[rs1_addr] : regs_q[rs1_addr];
    assign rs2_data = (BYPASS != 0) ? regs_d[rs2_addr] : regs_q[rs2_addr];

    // A writeback arriving this cycle already supplies the data through the
    // bypass, so the reader need not stall on it. busy_q[0] is never set when
    // register 0 is hardwired.
    assign rs1_busy = busy_q[rs1_addr] &&
                      !((BYPASS != 0) && wb_en && (wb_addr == rs1_addr));
    assign rs2_busy = busy_q[rs2_addr] &&
                      !((BYPASS != 0) && wb_en && (wb_addr == rs2_addr));

    // Scoreboard next state: clear on writeback, then set on issue so a
    // same-address issue keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_act) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (iss_act) begin
            busy_d[iss_rd] = 1'b1;
        end
    end

    // Incremental popcount: +1 when an issue lands on a clear bit, -1 when a
    // writeback clears a set bit that is not simultaneously re-issued.
    assign cnt_inc = iss_act && !busy_q[iss_rd];
    assign cnt_dec = wb_act && busy_q[wb_addr] && !(iss_act && (iss_rd == wb_addr));
    assign cnt_d   = cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);

    // Protocol errors: double issue without an intervening writeback, or a
    // writeback nobody was waiting for.
    assign err_d = err_q ||
                   (iss_act && busy_q[iss_rd] && !(wb_act && (wb_addr == iss_rd))) ||
                   (wb_act && !busy_q[wb_addr]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign busy_cnt = cnt_q;
    assign sb_err   = err_q;

endmodule
